// File: rtl/uno_pkg.sv
// Shared encodings and coefficient tables for the uno sequencer.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package uno_pkg;

   // Default datapath width: Q4.8 fixed point.
   localparam int MAC_BW_DEF = 12;

   // Number of coefficients held per polynomial op.
   localparam int COEF_ORDER = 3;

   typedef enum logic [1:0] {
      OP_MAC = 2'b00,
      OP_DIV = 2'b01,
      OP_EXP = 2'b10,
      OP_LOG = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   typedef logic [MAC_BW_DEF-1:0] coef_t;

   // Tables are stored lowest degree at index 0 (rightmost element).
   // 1/x around 0.75: 1.332, 1.777, 2.371
   localparam logic [COEF_ORDER-1:0][MAC_BW_DEF-1:0] DIV_COEF = {12'h25F, 12'h1C7, 12'h155};
   // e^x Taylor: 1, 1, 0.5
   localparam logic [COEF_ORDER-1:0][MAC_BW_DEF-1:0] EXP_COEF = {12'h080, 12'h100, 12'h100};
   // ln(1+x) Taylor: 0, 1, -0.5
   localparam logic [COEF_ORDER-1:0][MAC_BW_DEF-1:0] LOG_COEF = {12'hF80, 12'h100, 12'h000};

endpackage

// File: rtl/uno_coeff_rom.sv
// Coefficient lookup: op and polynomial degree index to Q4.8 coefficient.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module uno_coeff_rom
   import uno_pkg::*;
#(
   parameter int MAC_BW = MAC_BW_DEF,
   parameter int IDX_W  = 8
) (
   input  logic [1:0]        op,
   input  logic [IDX_W-1:0]  idx,
   output logic [MAC_BW-1:0] coeff
);

   coef_t raw;

   // Select the table row for the op; MAC and out-of-range degrees read as 0.
   always_comb begin
      raw = '0;
      for (int i = 0; i < COEF_ORDER; i++) begin
         if (32'(idx) == i) begin
            case (op_e'(op))
               OP_DIV:  raw = DIV_COEF[i];
               OP_EXP:  raw = EXP_COEF[i];
               OP_LOG:  raw = LOG_COEF[i];
               default: raw = '0;
            endcase
         end
      end
   end

   assign coeff = MAC_BW'(raw);

endmodule

// File: rtl/uno_seq.sv
// Sequencer that turns one uno operation request into its per-cycle control stream.
// Latency: request accepted at T, steps T+1..T+N, done at T+N+1, ready again at T+N+2.
// Backpressure: req_ready is high only in IDLE; requests in any other state are held off.
module uno_seq
   import uno_pkg::*;
#(
   parameter int MAC_BW = MAC_BW_DEF,
   parameter int ORDER  = 3,
   parameter int LEN_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [LEN_W-1:0]  req_len,
   output logic [1:0]        uo_op,
   output logic [MAC_BW-1:0] uo_coeff,
   output logic              uo_first_cycle,
   output logic              uo_last_cycle,
   output logic              uo_acc_en,
   output logic              busy,
   output logic              done
);

   // Counter must hold both a MAC length and the polynomial step index.
   localparam int ORD_W = $clog2(ORDER + 1);
   localparam int CNT_W = (LEN_W > ORD_W) ? LEN_W : ORD_W;

   state_e           state;
   state_e           state_nxt;
   logic [1:0]       op_q;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] n_q;
   logic [CNT_W-1:0] n_req;
   logic [CNT_W-1:0] rom_idx;
   logic [MAC_BW-1:0] rom_coeff;
   logic             accept;
   logic             in_run;
   logic             step_last;
   logic             in_poly;

   assign req_ready = (state == ST_IDLE);
   assign accept    = req_valid && req_ready;
   assign in_run    = (state == ST_RUN);
   assign step_last = (cnt == n_q);

   // Last step index for the incoming request; a zero-length MAC still runs one step.
   always_comb begin
      n_req = CNT_W'(ORDER);
      if (req_op == OP_MAC) begin
         n_req = (req_len == '0) ? '0 : CNT_W'(req_len - LEN_W'(1));
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next state: IDLE -> RUN on accept, RUN -> DONE on last step, DONE lasts one cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (accept) state_nxt = ST_RUN;
         ST_RUN:  if (step_last) state_nxt = ST_DONE;
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Latch the request and advance the step counter while running.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q <= '0;
         cnt  <= '0;
         n_q  <= '0;
      end else if (accept) begin
         op_q <= req_op;
         cnt  <= '0;
         n_q  <= n_req;
      end else if (in_run && !step_last) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // Horner order walks the table from the highest degree down.
   assign in_poly = (op_q != OP_MAC) && (32'(cnt) < ORDER);
   assign rom_idx = CNT_W'(ORDER - 1) - cnt;

   uno_coeff_rom #(
      .MAC_BW (MAC_BW),
      .IDX_W  (CNT_W)
   ) u_rom (
      .op    (op_q),
      .idx   (rom_idx),
      .coeff (rom_coeff)
   );

   // Output decode from registered state only; control strobes are quiet outside RUN.
   always_comb begin
      uo_op          = op_q;
      uo_coeff       = '0;
      uo_first_cycle = 1'b0;
      uo_last_cycle  = 1'b0;
      uo_acc_en      = 1'b0;
      busy           = (state != ST_IDLE);
      done           = (state == ST_DONE);
      if (in_run) begin
         uo_first_cycle = (cnt == '0);
         uo_last_cycle  = step_last;
         uo_acc_en      = (op_q == OP_MAC) && (cnt != '0);
         if (in_poly) begin
            uo_coeff = rom_coeff;
         end
      end
   end

endmodule
